// File: rtl/count4_arb.sv
// count4_arb: two-requester round-robin scheduler for a shared 4-bit loadable
// down-counter. Grants the counter, loads the owner's start value, issues
// paced decrements down to zero, then pulses done to the owner.
// Optional feature: define COUNT4_ARB_ABORT_EN to add the abort input.
module count4_arb #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] val0,
  input  logic [3:0] val1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic       cnt_set,
  output logic [3:0] cnt_set_count,
  output logic       cnt_dec,
  input  logic [3:0] cnt_count
`ifdef COUNT4_ARB_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned PW = 4;
  localparam int unsigned VW = 4;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic          owner, owner_nxt;
  logic          last, last_nxt;
  logic [VW-1:0] ld_val, ld_val_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic          abort_i;
  logic          tick;

`ifdef COUNT4_ARB_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign tick = (pre == PS_LAST);

  // State, owner, last-served pointer, captured value and prescaler registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      ld_val <= '0;
      pre    <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      last   <= last_nxt;
      ld_val <= ld_val_nxt;
      pre    <= pre_nxt;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    last_nxt      = last;
    ld_val_nxt    = ld_val;
    pre_nxt       = pre;
    gnt0          = 1'b0;
    gnt1          = 1'b0;
    done0         = 1'b0;
    done1         = 1'b0;
    busy          = 1'b0;
    cnt_set       = 1'b0;
    cnt_set_count = '0;
    cnt_dec       = 1'b0;

    if (state != S_IDLE) begin
      busy = 1'b1;
      gnt0 = ~owner;
      gnt1 = owner;
    end

    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          // on a tie, serve the requester that was not served last
          owner_nxt  = (req0 && req1) ? ~last : req1;
          ld_val_nxt = owner_nxt ? val1 : val0;
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_i) begin
          last_nxt  = owner;
          state_nxt = S_IDLE;
        end else begin
          cnt_set       = 1'b1;
          cnt_set_count = ld_val;
          pre_nxt       = '0;
          state_nxt     = S_RUN;
        end
      end
      S_RUN: begin
        pre_nxt = tick ? '0 : PW'(pre + 1'b1);
        if (abort_i) begin
          last_nxt  = owner;
          state_nxt = S_IDLE;
        end else if (cnt_count == '0) begin
          state_nxt = S_DONE;
        end else begin
          cnt_dec = tick;
        end
      end
      S_DONE: begin
        done0     = ~owner;
        done1     = owner;
        last_nxt  = owner;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_count4_arb.sv
// tb_count4_arb: directed bench for count4_arb with a behavioural count4
// beside each instance (PRESCALE=1 and PRESCALE=4).
module tb_count4_arb;

  logic       clk;
  logic       reset;
  logic       req0, req1, abort;
  logic [3:0] val0, val1;
  logic       gnt0, gnt1, done0, done1, busy, cnt_set, cnt_dec;
  logic [3:0] cnt_set_count, cnt_count;

  logic       reqb;
  logic [3:0] valb;
  logic       gnt0_b, gnt1_b, done0_b, done1_b, busy_b, cnt_set_b, cnt_dec_b;
  logic [3:0] cnt_set_count_b, cnt_count_b;

  int n_pass  = 0;
  int n_total = 0;

  logic       tr_g0   [1:64];
  logic       tr_g1   [1:64];
  logic       tr_d0   [1:64];
  logic       tr_d1   [1:64];
  logic       tr_busy [1:64];
  logic       tr_dec  [1:64];
  logic       tr_set  [1:64];
  logic [3:0] tr_sc   [1:64];
  logic [3:0] tr_cnt  [1:64];

  count4_arb #(.PRESCALE(1)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .val0(val0), .val1(val1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .cnt_set(cnt_set), .cnt_set_count(cnt_set_count), .cnt_dec(cnt_dec),
    .cnt_count(cnt_count)
`ifdef COUNT4_ARB_ABORT_EN
    , .abort(abort)
`endif
  );

  count4_arb #(.PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(reqb), .req1(1'b0), .val0(valb), .val1(4'h0),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .busy(busy_b),
    .cnt_set(cnt_set_b), .cnt_set_count(cnt_set_count_b), .cnt_dec(cnt_dec_b),
    .cnt_count(cnt_count_b)
`ifdef COUNT4_ARB_ABORT_EN
    , .abort(1'b0)
`endif
  );

  // Behavioural count4 models: load has priority over decrement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_count   <= 4'h0;
      cnt_count_b <= 4'h0;
    end else begin
      if (cnt_set) cnt_count <= cnt_set_count;
      else if (cnt_dec) cnt_count <= cnt_count - 4'h1;
      if (cnt_set_b) cnt_count_b <= cnt_set_count_b;
      else if (cnt_dec_b) cnt_count_b <= cnt_count_b - 4'h1;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Record ncyc cycles after the grant edge; at cycle drop_k release requests
  // and scramble the start values
  task automatic watch(input int ncyc, input int drop_k);
    for (int k = 1; k <= ncyc; k++) begin
      cyc();
      tr_g0[k]   = gnt0;
      tr_g1[k]   = gnt1;
      tr_d0[k]   = done0;
      tr_d1[k]   = done1;
      tr_busy[k] = busy;
      tr_dec[k]  = cnt_dec;
      tr_set[k]  = cnt_set;
      tr_sc[k]   = cnt_set_count;
      tr_cnt[k]  = cnt_count;
      if (k == drop_k) begin
        req0 = 1'b0;
        req1 = 1'b0;
        val0 = 4'hC;
        val1 = 4'hC;
      end
    end
  endtask

  initial begin
    int n_g0, n_g1, n_dec, at_d0, at_d1;
    logic saw_f;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; abort = 1'b0;
    val0 = 4'h0; val1 = 4'h0; reqb = 1'b0; valb = 4'h0;
    repeat (2) cyc();
    chk("reset_outs", 32'({gnt0, gnt1, done0, done1, busy, cnt_set, cnt_dec}), 32'h0);
    chk("reset_setcnt", 32'(cnt_set_count), 32'h0);
    chk("reset_busy_b", 32'(busy_b), 32'h0);
    reset = 1'b0;
    cyc();

    // reset in the middle of a N=9 service after three decrements
    val0 = 4'h9; req0 = 1'b1;
    cyc();
    req0 = 1'b0;
    repeat (4) cyc();
    chk("midrun_cnt", 32'(cnt_count), 32'h6);
    chk("midrun_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    chk("midrun_rst_outs", 32'({gnt0, gnt1, done0, done1, busy, cnt_set, cnt_dec}), 32'h0);
    chk("midrun_rst_setcnt", 32'(cnt_set_count), 32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    // normal service after reset, N=2
    val0 = 4'h2; req0 = 1'b1;
    watch(7, 1);
    n_g0 = 0; at_d0 = 0;
    for (int k = 1; k <= 7; k++) begin
      if (tr_g0[k]) n_g0++;
      if (tr_d0[k]) at_d0 = k;
    end
    chk("post_rst_gnt0_len", 32'(n_g0), 32'd5);
    chk("post_rst_done0_at", 32'(at_d0), 32'd5);
    chk("post_rst_idle", 32'(tr_busy[6]), 32'h0);
    cyc();

    // N=5, PRESCALE=1
    val0 = 4'h5; req0 = 1'b1;
    watch(10, 1);
    n_g0 = 0; n_g1 = 0; n_dec = 0; at_d0 = 0;
    for (int k = 1; k <= 10; k++) begin
      if (tr_g0[k]) n_g0++;
      if (tr_g1[k]) n_g1++;
      if (tr_dec[k]) n_dec++;
      if (tr_d0[k]) at_d0 = k;
    end
    chk("n5_gnt0_len", 32'(n_g0), 32'd8);
    chk("n5_gnt1_len", 32'(n_g1), 32'd0);
    chk("n5_dec_len", 32'(n_dec), 32'd5);
    chk("n5_done0_at", 32'(at_d0), 32'd8);
    chk("n5_load_set", 32'(tr_set[1]), 32'h1);
    chk("n5_load_val", 32'(tr_sc[1]), 32'h5);
    chk("n5_setcnt_run", 32'(tr_sc[2]), 32'h0);
    for (int k = 2; k <= 7; k++) chk("n5_count_seq", 32'(tr_cnt[k]), 32'(7 - k));
    chk("n5_idle_after", 32'(tr_busy[9]), 32'h0);
    cyc();

    // start value 0 on requester 1
    val1 = 4'h0; req1 = 1'b1;
    watch(6, 1);
    n_g1 = 0; n_dec = 0; at_d1 = 0;
    for (int k = 1; k <= 6; k++) begin
      if (tr_g1[k]) n_g1++;
      if (tr_dec[k]) n_dec++;
      if (tr_d1[k]) at_d1 = k;
    end
    chk("z_gnt1_len", 32'(n_g1), 32'd3);
    chk("z_dec_len", 32'(n_dec), 32'd0);
    chk("z_done1_at", 32'(at_d1), 32'd3);
    chk("z_load", 32'({tr_set[1], tr_sc[1]}), 32'h10);
    cyc();

    // both requesters held: services alternate 0,1,0,1 with one idle cycle between
    val0 = 4'h1; val1 = 4'h2; req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      chk("alt_done0", 32'(done0), 32'((k == 4) || (k == 15)));
      chk("alt_done1", 32'(done1), 32'((k == 10) || (k == 21)));
      chk("alt_busy", 32'(busy), 32'(!((k == 5) || (k == 11) || (k == 16))));
      chk("alt_onehot", 32'(gnt0 & gnt1), 32'h0);
      if (k == 2) chk("alt_first_gnt0", 32'(gnt0), 32'h1);
      if (k == 7) chk("alt_second_gnt1", 32'(gnt1), 32'h1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) cyc();

    // PRESCALE=4, N=3 on the second instance
    valb = 4'h3; reqb = 1'b1;
    n_g0 = 0; at_d0 = 0; saw_f = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      cyc();
      if (k == 1) begin
        reqb = 1'b0;
        valb = 4'hE;
      end
      if (gnt0_b) n_g0++;
      if (done0_b) at_d0 = k;
      if (cnt_count_b == 4'hF) saw_f = 1'b1;
      chk("p4_dec", 32'(cnt_dec_b), 32'((k == 5) || (k == 9) || (k == 13)));
    end
    chk("p4_gnt0_len", 32'(n_g0), 32'd15);
    chk("p4_done0_at", 32'(at_d0), 32'd15);
    chk("p4_no_wrap", 32'(saw_f), 32'h0);
    chk("p4_final_cnt", 32'(cnt_count_b), 32'h0);

`ifdef COUNT4_ARB_ABORT_EN
    // abort mid-RUN with req1 pending
    val0 = 4'h9; val1 = 4'h1; req0 = 1'b1; req1 = 1'b1;
    cyc();
    req0 = 1'b0;
    chk("ab_gnt0", 32'(gnt0), 32'h1);
    repeat (4) cyc();
    chk("ab_cnt6", 32'(cnt_count), 32'h6);
    abort = 1'b1;
    #1;
    chk("ab_no_dec", 32'({cnt_dec, cnt_set}), 32'h0);
    cyc();
    abort = 1'b0;
    chk("ab_idle", 32'({gnt0, gnt1, done0, done1, busy}), 32'h0);
    cyc();
    chk("ab_gnt1_next", 32'({gnt1, cnt_set}), 32'h3);
    req1 = 1'b0;
    repeat (8) cyc();
    chk("ab_settled", 32'(busy), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
